instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Inverse of the decode stage: packs RV32I instruction fields (opclass, registers, funct3, alternate bit, immediate) into legal 32-bit instruction words.
- Queues the encoded words in a small FIFO.
- Streams the words to the instruction-memory write port with an auto-incrementing byte address.
- Used by the test/boot path to load programs into instruction memory without an external assembler.

Parameters:
- DEPTH, 4, FIFO entries (power of two, at least 2).
- ADDR_W, 32, width of the write address.
- BASE_ADDR, 0, first write address after reset or flush.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of the FIFO and the address counter.
- in_valid  in  1  request valid.
- in_ready  out  1  request can be accepted this cycle.
- in_class  in  4  opclass: 0 LOAD, 1 OPIMM, 2 AUIPC, 3 STORE, 4 OP, 5 LUI, 6 BRANCH, 7 JALR, 8 JAL; 9-15 illegal.
- in_rd  in  5  destination register.
- in_rs1  in  5  first source register.
- in_rs2  in  5  second source register.
- in_funct3  in  3  funct3 field.
- in_alt  in  1  funct7 bit 5 (sub, sra, srai).
- in_imm  in  32  immediate, given as a full signed value; U-type takes bits 31:12 directly.
- err  out  1  one-cycle pulse: an illegal opclass was accepted.
- wr_valid  out  1  encoded word is available.
- wr_ready  in  1  the memory accepts the word this cycle.
- wr_addr  out  ADDR_W  byte address for the current head word.
- wr_data  out  32  encoded instruction at the FIFO head.

Behaviour:
- Reset (rst_n low, asynchronous): FIFO empty, wr_addr = BASE_ADDR, err = 0, wr_valid = 0, in_ready = 1. wr_data is don't-care.
- in_ready is 1 when the FIFO count is below DEPTH. It is combinational from the registered count only, never from wr_ready.
- Accept occurs when in_valid and in_ready are both high.
  - Legal class: the encoded word is written at the tail.
  - Illegal class: nothing is written; err pulses high on the next cycle.
- Latency: a word accepted in cycle N shows wr_valid = 1 in cycle N+1 when the FIFO was empty.
- Pop occurs when wr_valid and wr_ready are both high. The head advances and wr_addr increases by 4, wrapping modulo 2^ADDR_W.
- wr_valid, wr_data and wr_addr stay stable while wr_valid = 1 and wr_ready = 0.
- Simultaneous accept and pop: allowed when the FIFO is non-empty and not full; the count is unchanged.
- When the FIFO is full, in_ready = 0, so no accept happens even if a pop occurs in the same cycle.
- flush has priority over accept and pop in the same cycle.
  - Next cycle: count = 0, wr_addr = BASE_ADDR, err = 0.
  - The request presented during the flush cycle is dropped.
- Reset asserted mid-transfer discards all queued words at once.
- Encoding fields (opcode taken from the class):
  - I-type (LOAD 0000011, OPIMM 0010011, JALR 1100111): imm[11:0], rs1, funct3, rd.
  - OPIMM with funct3 001 or 101: bits 31:25 are {0, in_alt, 00000}; bits 24:20 are imm[4:0].
  - JALR: funct3 is forced to 000.
  - S-type (STORE 0100011): imm[11:5], rs2, rs1, funct3, imm[4:0].
  - R-type (OP 0110011): {0, in_alt, 00000}, rs2, rs1, funct3, rd.
  - B-type (BRANCH 1100011): imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11]. imm[0] is ignored.
  - U-type (LUI 0110111, AUIPC 0010111): imm[31:12], rd.
  - J-type (JAL 1101111): imm[20], imm[10:1], imm[11], imm[19:12], rd. imm[0] is ignored.
  - Fields not used by a format are ignored; no range checking is done on the immediate.

Test Plan:
- Reset, then a single OPIMM request (rd=1, rs1=0, funct3=000, imm=5) -> wr_valid rises the next cycle; wr_addr=0x0, wr_data=0x00500093; then err stays 0.
- Back-to-back OP add then sub (rd=3, rs1=1, rs2=2, alt 0 then 1), with wr_ready=1 -> words 0x002081B3 at 0x0 and 0x402081B3 at 0x4.
- STORE (rs1=1, rs2=2, funct3=010, imm=8), JAL (rd=1, imm=8), LUI (rd=5, imm=0x12345000), OPIMM srai (rd=1, rs1=1, funct3=101, alt=1, imm=3) -> 0x0020A423, 0x008000EF, 0x123452B7, 0x4030D093.
- Hold wr_ready=0 and push DEPTH+2 requests -> in_ready drops after DEPTH accepts; wr_data is stable. Then release wr_ready -> DEPTH words in order at addresses 0x0 through 4*(DEPTH-1).
- Illegal class 12 between two legal requests -> err pulses exactly once; only 2 words are written, at consecutive addresses.
- flush asserted while the FIFO holds 3 words, with a simultaneous request -> next cycle wr_valid=0, wr_addr=BASE_ADDR; the next legal request is written at BASE_ADDR.

Source files
------------

// File: rtl/instr_encoder.sv
// RV32I field packer: encodes requests into 32-bit words, buffers them in a small FIFO
// and streams them to an instruction-memory write port with an auto-incrementing address.
module instr_encoder #(
   parameter int                DEPTH     = 4,
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_class,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [2:0]        in_funct3,
   input  logic              in_alt,
   input  logic [31:0]       in_imm,
   output logic              err,
   output logic              wr_valid,
   input  logic              wr_ready,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   localparam logic [3:0] CL_LOAD   = 4'd0;
   localparam logic [3:0] CL_OPIMM  = 4'd1;
   localparam logic [3:0] CL_AUIPC  = 4'd2;
   localparam logic [3:0] CL_STORE  = 4'd3;
   localparam logic [3:0] CL_OP     = 4'd4;
   localparam logic [3:0] CL_LUI    = 4'd5;
   localparam logic [3:0] CL_BRANCH = 4'd6;
   localparam logic [3:0] CL_JALR   = 4'd7;
   localparam logic [3:0] CL_JAL    = 4'd8;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   logic [31:0]       mem_q [DEPTH];
   logic [31:0]       mem_d [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              err_q, err_d;

   logic [31:0] enc_word;
   logic        enc_legal;
   logic        accept;
   logic        push;
   logic        pop;

   always_comb begin
      enc_word  = '0;
      enc_legal = 1'b1;
      case (in_class)
         CL_LOAD:   enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_LOAD};
         CL_OPIMM: begin
            // Shift-immediates carry a funct7-style upper field with the alternate bit.
            if (in_funct3 == 3'b001 || in_funct3 == 3'b101)
               enc_word = {1'b0, in_alt, 5'b00000, in_imm[4:0], in_rs1, in_funct3, in_rd, OPC_OPIMM};
            else
               enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_OPIMM};
         end
         CL_AUIPC:  enc_word = {in_imm[31:12], in_rd, OPC_AUIPC};
         CL_STORE:  enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OPC_STORE};
         CL_OP:     enc_word = {1'b0, in_alt, 5'b00000, in_rs2, in_rs1, in_funct3, in_rd, OPC_OP};
         CL_LUI:    enc_word = {in_imm[31:12], in_rd, OPC_LUI};
         CL_BRANCH: enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                                in_imm[4:1], in_imm[11], OPC_BRANCH};
         CL_JALR:   enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, OPC_JALR};
         CL_JAL:    enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OPC_JAL};
         default:   enc_legal = 1'b0;
      endcase
   end

   assign in_ready = (count_q != FULL_CNT);
   assign wr_valid = (count_q != '0);
   assign wr_data  = mem_q[rd_ptr_q];
   assign wr_addr  = addr_q;
   assign err      = err_q;

   assign accept = in_valid && in_ready && !flush;
   assign push   = accept && enc_legal;
   assign pop    = wr_valid && wr_ready && !flush;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      addr_d   = addr_q;
      err_d    = 1'b0;
      if (flush) begin
         // Flush wins over any accept or pop presented in the same cycle.
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         addr_d   = BASE_ADDR;
      end else begin
         err_d = accept && !enc_legal;
         if (push) begin
            mem_d[wr_ptr_q] = enc_word;
            wr_ptr_d        = wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            addr_d   = addr_q + ADDR_W'(4);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         addr_q   <= BASE_ADDR;
         err_q    <= 1'b0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         addr_q   <= addr_d;
         err_q    <= err_d;
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed program snippets plus random requests, checked by a
// scoreboard fed from an arithmetic RV32I encoding model.
module tb_instr_encoder;

   localparam int          DEPTH  = 4;
   localparam int          ADDR_W = 32;
   localparam logic [31:0] BASE   = 32'h0000_0000;

   logic              clk;
   logic              rst_n;
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [3:0]        in_class;
   logic [4:0]        in_rd;
   logic [4:0]        in_rs1;
   logic [4:0]        in_rs2;
   logic [2:0]        in_funct3;
   logic              in_alt;
   logic [31:0]       in_imm;
   logic              err;
   logic              wr_valid;
   logic              wr_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic [31:0]       wr_data;

   instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_class(in_class),
      .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
      .in_alt(in_alt), .in_imm(in_imm), .err(err),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   int          assert_cnt = 0;
   int          fail_cnt   = 0;
   logic [63:0] exp_q[$];
   logic [31:0] exp_addr;
   int          err_exp  = 0;
   int          err_seen = 0;
   bit          mon_en   = 0;

   int unsigned op_tab [9] = '{32'h03, 32'h13, 32'h17, 32'h23, 32'h33, 32'h37, 32'h63, 32'h67, 32'h6F};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      assert_cnt++;
      if (act !== exp) begin
         fail_cnt++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference encoding built from shifts and masks of the field values.
   function automatic logic [31:0] ref_encode(input int unsigned cls, input int unsigned rd,
                                              input int unsigned rs1, input int unsigned rs2,
                                              input int unsigned f3, input int unsigned alt,
                                              input int unsigned imm);
      int unsigned w;
      int unsigned op;
      if (cls > 8) return 32'h0;
      op = op_tab[cls];
      case (cls)
         0, 7:    w = op | (rd << 7) | ((cls == 7 ? 0 : f3) << 12) | (rs1 << 15) | ((imm & 32'hfff) << 20);
         1: begin
            if (f3 == 1 || f3 == 5)
               w = op | (rd << 7) | (f3 << 12) | (rs1 << 15) | ((imm & 31) << 20) | (alt << 30);
            else
               w = op | (rd << 7) | (f3 << 12) | (rs1 << 15) | ((imm & 32'hfff) << 20);
         end
         2, 5:    w = (imm & 32'hffff_f000) | (rd << 7) | op;
         3:       w = op | ((imm & 31) << 7) | (f3 << 12) | (rs1 << 15) | (rs2 << 20) | (((imm >> 5) & 127) << 25);
         4:       w = op | (rd << 7) | (f3 << 12) | (rs1 << 15) | (rs2 << 20) | (alt << 30);
         6:       w = op | (((imm >> 11) & 1) << 7) | (((imm >> 1) & 15) << 8) | (f3 << 12) | (rs1 << 15)
                     | (rs2 << 20) | (((imm >> 5) & 63) << 25) | (((imm >> 12) & 1) << 31);
         default: w = op | (rd << 7) | (((imm >> 12) & 255) << 12) | (((imm >> 11) & 1) << 20)
                     | (((imm >> 1) & 1023) << 21) | (((imm >> 20) & 1) << 31);
      endcase
      return w;
   endfunction

   // ---------------- driver tasks ----------------
   // Called at posedge+1; presents one request for one cycle and updates the model on accept.
   task automatic present(input logic [3:0] cls, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [2:0] f3, input logic alt,
                          input logic [31:0] imm, input logic [31:0] word, input bit fl,
                          output bit acc);
      in_valid  = 1'b1;
      in_class  = cls;
      in_rd     = rd;
      in_rs1    = rs1;
      in_rs2    = rs2;
      in_funct3 = f3;
      in_alt    = alt;
      in_imm    = imm;
      flush     = fl;
      @(negedge clk);
      acc = in_ready && !fl;
      @(posedge clk);
      if (fl) begin
         exp_q.delete();
         exp_addr = BASE;
      end else if (acc) begin
         if (cls < 4'd9) begin
            exp_q.push_back({exp_addr, word});
            exp_addr = exp_addr + 32'd4;
         end else begin
            err_exp++;
         end
      end
      #1;
      in_valid = 1'b0;
      flush    = 1'b0;
   endtask

   task automatic send(input logic [3:0] cls, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [2:0] f3, input logic alt,
                       input logic [31:0] imm, input logic [31:0] word);
      bit acc;
      acc = 0;
      for (int t = 0; t < 100 && !acc; t++)
         present(cls, rd, rs1, rs2, f3, alt, imm, word, 1'b0, acc);
      if (!acc) begin
         assert_cnt++;
         fail_cnt++;
         $display("FAIL send_timeout: got in_ready low for 100 cycles expected accept");
      end
   endtask

   task automatic do_flush();
      bit acc;
      present(4'd12, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'h0, 32'h0, 1'b1, acc);
      check("flush_wr_valid", {31'b0, wr_valid}, 32'd0);
      check("flush_wr_addr", wr_addr, BASE);
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while ((exp_q.size() != 0 || wr_valid) && t < 200) begin
         @(posedge clk);
         #1;
         t++;
      end
      check("drain_queue_left", exp_q.size(), 32'd0);
   endtask

   // ---------------- monitor ----------------
   logic        hold_q = 1'b0;
   logic [31:0] hold_data;
   logic [31:0] hold_addr;

   always @(negedge clk) begin
      if (mon_en) begin
         logic [63:0] e;
         check("in_ready", {31'b0, in_ready}, (exp_q.size() < DEPTH) ? 32'd1 : 32'd0);
         check("wr_valid", {31'b0, wr_valid}, (exp_q.size() != 0) ? 32'd1 : 32'd0);
         if (err) err_seen++;
         if (hold_q) begin
            check("stall_wr_data", wr_data, hold_data);
            check("stall_wr_addr", wr_addr, hold_addr);
         end
         if (!flush && wr_valid && wr_ready) begin
            if (exp_q.size() == 0) begin
               assert_cnt++;
               fail_cnt++;
               $display("FAIL unexpected_word: got %h at %h expected no word", wr_data, wr_addr);
            end else begin
               e = exp_q.pop_front();
               check("wr_addr", wr_addr, e[63:32]);
               check("wr_data", wr_data, e[31:0]);
            end
         end
         hold_q    = wr_valid && !wr_ready && !flush;
         hold_data = wr_data;
         hold_addr = wr_addr;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no end of test expected finish");
      fail_cnt++;
      $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      bit          acc;
      int          n_acc;
      int          err_before;
      int unsigned r_cls, r_rd, r_rs1, r_rs2, r_f3, r_alt, r_imm;

      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; wr_ready = 1'b0;
      in_class = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_funct3 = '0; in_alt = 1'b0; in_imm = '0;
      exp_addr = BASE;
      repeat (3) @(posedge clk);
      #1;
      check("reset_wr_valid", {31'b0, wr_valid}, 32'd0);
      check("reset_in_ready", {31'b0, in_ready}, 32'd1);
      check("reset_err", {31'b0, err}, 32'd0);
      check("reset_wr_addr", wr_addr, BASE);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      mon_en = 1;

      // single OPIMM: one-cycle latency from accept to wr_valid
      wr_ready = 1'b1;
      present(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5, 32'h0050_0093, 1'b0, acc);
      check("first_accept", {31'b0, acc}, 32'd1);
      check("first_wr_valid", {31'b0, wr_valid}, 32'd1);
      check("first_wr_addr", wr_addr, 32'h0);
      check("first_wr_data", wr_data, 32'h0050_0093);
      @(posedge clk);
      #1;
      check("first_err", {31'b0, err}, 32'd0);
      wait_drain();

      // add / sub back to back
      do_flush();
      send(4'd4, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'h0, 32'h0020_81B3);
      send(4'd4, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 32'h0, 32'h4020_81B3);
      wait_drain();

      // store, jal, lui, srai
      do_flush();
      send(4'd3, 5'd0, 5'd1, 5'd2, 3'd2, 1'b0, 32'd8, 32'h0020_A423);
      send(4'd8, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd8, 32'h0080_00EF);
      send(4'd5, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h1234_5000, 32'h1234_52B7);
      send(4'd1, 5'd1, 5'd1, 5'd0, 3'd5, 1'b1, 32'd3, 32'h4030_D093);
      wait_drain();

      // fill with the write port stalled
      do_flush();
      wr_ready = 1'b0;
      n_acc = 0;
      for (int i = 0; i < DEPTH + 2; i++) begin
         r_rd = $urandom_range(0, 31); r_rs1 = $urandom_range(0, 31); r_rs2 = $urandom_range(0, 31);
         present(4'd4, 5'(r_rd), 5'(r_rs1), 5'(r_rs2), 3'd0, 1'b0, 32'h0,
                 ref_encode(4, r_rd, r_rs1, r_rs2, 0, 0, 0), 1'b0, acc);
         if (acc) n_acc++;
      end
      check("full_accepts", n_acc, DEPTH);
      check("full_in_ready", {31'b0, in_ready}, 32'd0);
      wr_ready = 1'b1;
      wait_drain();

      // illegal class between two legal requests
      do_flush();
      err_before = err_seen;
      send(4'd0, 5'd2, 5'd3, 5'd0, 3'd2, 1'b0, 32'h10, ref_encode(0, 2, 3, 0, 2, 0, 32'h10));
      present(4'd12, 5'd1, 5'd1, 5'd1, 3'd0, 1'b0, 32'h0, 32'h0, 1'b0, acc);
      check("illegal_accept", {31'b0, acc}, 32'd1);
      check("illegal_err_pulse", {31'b0, err}, 32'd1);
      @(posedge clk);
      #1;
      check("illegal_err_low", {31'b0, err}, 32'd0);
      send(4'd6, 5'd0, 5'd4, 5'd5, 3'd1, 1'b0, 32'hFFFF_FFF8, ref_encode(6, 0, 4, 5, 1, 0, 32'hFFFF_FFF8));
      wait_drain();
      check("illegal_err_count", err_seen - err_before, 32'd1);

      // flush with three queued words and a simultaneous request
      do_flush();
      wr_ready = 1'b0;
      for (int i = 0; i < 3; i++)
         send(4'd5, 5'(i + 1), 5'd0, 5'd0, 3'd0, 1'b0, 32'hABCD_E000, ref_encode(5, i + 1, 0, 0, 0, 0, 32'hABCD_E000));
      present(4'd4, 5'd7, 5'd7, 5'd7, 3'd0, 1'b0, 32'h0, 32'h0, 1'b1, acc);
      check("flush3_wr_valid", {31'b0, wr_valid}, 32'd0);
      check("flush3_wr_addr", wr_addr, BASE);
      wr_ready = 1'b1;
      send(4'd7, 5'd1, 5'd6, 5'd0, 3'd3, 1'b0, 32'h7FF, 32'h7FF3_00E7);
      check("post_flush_addr", wr_addr, BASE);
      check("post_flush_data", wr_data, 32'h7FF3_00E7);
      wait_drain();

      // random traffic with random back-pressure and occasional flush
      for (int i = 0; i < 400; i++) begin
         wr_ready = 1'($urandom_range(0, 3) != 0);
         r_cls = $urandom_range(0, 9);
         if (r_cls == 9) r_cls = $urandom_range(9, 15);
         r_rd = $urandom_range(0, 31); r_rs1 = $urandom_range(0, 31); r_rs2 = $urandom_range(0, 31);
         r_f3 = $urandom_range(0, 7); r_alt = $urandom_range(0, 1); r_imm = $urandom();
         present(4'(r_cls), 5'(r_rd), 5'(r_rs1), 5'(r_rs2), 3'(r_f3), 1'(r_alt), r_imm,
                 ref_encode(r_cls, r_rd, r_rs1, r_rs2, r_f3, r_alt, r_imm),
                 ($urandom_range(0, 39) == 0), acc);
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
      end
      wr_ready = 1'b1;
      wait_drain();
      @(posedge clk);
      #1;
      check("total_err_pulses", err_seen, err_exp);

      $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
      $finish;
   end

endmodule
